// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and data port share one memory.
// Ties alternate between requesters; a stuck access is abandoned after TIMEOUT busy cycles.
module mem_arbiter #(
  parameter int          ADDR_W  = 16,
  parameter int          DATA_W  = 16,
  parameter logic [7:0]  TIMEOUT = 8'd32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              dm_rd_en,
  input  logic              dm_wr_en,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] if_rdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              if_done,
  output logic              dm_done,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  state_t            r_state;
  logic              r_last_dm;
  logic [7:0]        r_cnt;
  logic              r_err;
  logic              r_mem_en;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  logic              w_dm_req;
  logic              w_grant_dm;
  logic              w_grant_if;
  logic [7:0]        w_cnt_inc;
  logic              w_timeout;

  assign w_dm_req   = dm_rd_en | dm_wr_en;
  // On a tie the requester that did not win last time goes first.
  assign w_grant_dm = w_dm_req & (~if_req | ~r_last_dm);
  assign w_grant_if = if_req & (~w_dm_req | r_last_dm);
  assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_timeout  = ~mem_valid & (w_cnt_inc >= TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last_dm   <= 1'b0;
      r_cnt       <= 8'd0;
      r_err       <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_mem_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_dm) begin
            r_state     <= DM_BUSY;
            r_mem_en    <= 1'b1;
            r_mem_wr    <= dm_wr_en;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            r_last_dm   <= 1'b1;
            r_cnt       <= 8'd0;
          end else if (w_grant_if) begin
            r_state    <= IF_BUSY;
            r_mem_en   <= 1'b1;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= if_addr;
            r_last_dm  <= 1'b0;
            r_cnt      <= 8'd0;
          end
        end
        IF_BUSY: begin
          if (mem_valid) begin
            r_state    <= IDLE;
            r_if_rdata <= mem_rdata;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_timeout) begin
              r_state <= IDLE;
              r_err   <= 1'b1;
            end
          end
        end
        DM_BUSY: begin
          if (mem_valid) begin
            r_state <= IDLE;
            if (!r_mem_wr) r_dm_rdata <= mem_rdata;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_timeout) begin
              r_state <= IDLE;
              r_err   <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign err       = r_err;
  assign if_done   = (r_state == IF_BUSY) & mem_valid;
  assign dm_done   = (r_state == DM_BUSY) & mem_valid;
  assign if_stall  = if_req & ~if_done;
  assign dm_stall  = w_dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed per-cycle vector table for mem_arbiter, plus a hand-written timeout sequence.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_rd_en, dm_wr_en, mem_valid;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        mem_en, mem_wr, if_done, dm_done, if_stall, dm_stall, err;
  logic [15:0] mem_addr, mem_wdata, if_rdata, dm_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .dm_rd_en(dm_rd_en), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .if_rdata(if_rdata), .dm_rdata(dm_rdata),
    .if_done(if_done), .dm_done(dm_done), .if_stall(if_stall), .dm_stall(dm_stall),
    .err(err)
  );

  typedef struct packed {
    logic rst; logic if_req; logic [15:0] if_addr;
    logic dm_rd; logic dm_wr; logic [15:0] dm_addr; logic [15:0] dm_wdata;
    logic mv; logic [15:0] mrd;
  } in_t;

  typedef struct packed {
    logic en; logic wr; logic [15:0] addr; logic [15:0] wdata;
    logic ifd; logic dmd; logic ifs; logic dms; logic err;
    logic [15:0] ifr; logic [15:0] dmr;
  } out_t;

  typedef struct packed { in_t i; out_t o; } vec_t;

  vec_t tbl[$];

  task automatic v(input in_t a, input out_t b);
    tbl.push_back({a, b});
  endtask

  task automatic drive(input in_t x);
    rst = x.rst; if_req = x.if_req; if_addr = x.if_addr;
    dm_rd_en = x.dm_rd; dm_wr_en = x.dm_wr; dm_addr = x.dm_addr; dm_wdata = x.dm_wdata;
    mem_valid = x.mv; mem_rdata = x.mrd;
  endtask

  function automatic out_t sample();
    return {mem_en, mem_wr, mem_addr, mem_wdata, if_done, dm_done, if_stall, dm_stall,
            err, if_rdata, dm_rdata};
  endfunction

  task automatic chk(input string name, input logic [70:0] got, input logic [70:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
    else $display("vec %s ok: %h", name, got);
  endtask

  initial begin
    // inputs:  rst ifreq ifaddr dmrd dmwr dmaddr dmwdata mv mrd
    // outputs: en wr addr wdata ifd dmd ifs dms err ifr dmr
    // single fetch, response 3 cycles after mem_en
    v('{1,0,0,0,0,0,0,0,0},                     '{0,0,0,0,0,0,0,0,0,0,0});
    v('{0,1,16'h0010,0,0,0,0,0,0},              '{0,0,0,0,0,0,1,0,0,0,0});
    v('{0,1,16'h0010,0,0,0,0,0,0},              '{1,0,16'h0010,0,0,0,1,0,0,0,0});
    v('{0,1,16'h0010,0,0,0,0,0,0},              '{0,0,16'h0010,0,0,0,1,0,0,0,0});
    v('{0,1,16'h0010,0,0,0,0,0,0},              '{0,0,16'h0010,0,0,0,1,0,0,0,0});
    v('{0,1,16'h0010,0,0,0,0,1,16'hA5A5},       '{0,0,16'h0010,0,1,0,0,0,0,0,0});
    v('{0,0,0,0,0,0,0,1,16'hFFFF},              '{0,0,16'h0010,0,0,0,0,0,0,16'hA5A5,0});
    v('{0,0,0,0,0,0,0,0,0},                     '{0,0,16'h0010,0,0,0,0,0,0,16'hA5A5,0});
    // reset, then ties alternate starting with data
    v('{1,0,0,0,0,0,0,0,0},                     '{0,0,16'h0010,0,0,0,0,0,0,16'hA5A5,0});
    v('{0,1,16'h0020,1,0,16'h0200,0,0,0},       '{0,0,0,0,0,0,1,1,0,0,0});
    v('{0,1,16'h0020,1,0,16'h0200,0,1,16'hBEEF},'{1,0,16'h0200,0,0,1,1,0,0,0,0});
    v('{0,1,16'h0020,1,0,16'h0202,0,0,0},       '{0,0,16'h0200,0,0,0,1,1,0,0,16'hBEEF});
    v('{0,1,16'h0020,1,0,16'h0202,0,1,16'h1111},'{1,0,16'h0020,0,1,0,0,1,0,0,16'hBEEF});
    v('{0,1,16'h0022,1,0,16'h0202,0,0,0},       '{0,0,16'h0020,0,0,0,1,1,0,16'h1111,16'hBEEF});
    v('{0,1,16'h0022,1,0,16'h0202,0,1,16'h2222},'{1,0,16'h0202,0,0,1,1,0,0,16'h1111,16'hBEEF});
    v('{0,1,16'h0022,0,0,0,0,0,0},              '{0,0,16'h0202,0,0,0,1,0,0,16'h1111,16'h2222});
    v('{0,1,16'h0022,0,0,0,0,1,16'h3333},       '{1,0,16'h0022,0,1,0,0,0,0,16'h1111,16'h2222});
    // back-to-back fetch with new address; stray mem_valid in IDLE ignored
    v('{0,1,16'h0024,0,0,0,0,1,16'h4444},       '{0,0,16'h0022,0,0,0,1,0,0,16'h3333,16'h2222});
    v('{0,1,16'h0024,0,0,0,0,0,0},              '{1,0,16'h0024,0,0,0,1,0,0,16'h3333,16'h2222});
    v('{0,0,16'h0024,0,0,0,0,1,16'h5555},       '{0,0,16'h0024,0,1,0,0,0,0,16'h3333,16'h2222});
    v('{0,0,0,0,0,0,0,0,0},                     '{0,0,16'h0024,0,0,0,0,0,0,16'h5555,16'h2222});
    // write, then read+write treated as write, then fetch keeps mem_wdata
    v('{0,0,0,0,1,16'h0100,16'h1234,0,0},       '{0,0,16'h0024,0,0,0,0,1,0,16'h5555,16'h2222});
    v('{0,0,0,0,1,16'h0100,16'h1234,0,0},       '{1,1,16'h0100,16'h1234,0,0,0,1,0,16'h5555,16'h2222});
    v('{0,0,0,0,1,16'h0100,16'h1234,0,0},       '{0,1,16'h0100,16'h1234,0,0,0,1,0,16'h5555,16'h2222});
    v('{0,0,0,0,1,16'h0100,16'h1234,1,16'hDEAD},'{0,1,16'h0100,16'h1234,0,1,0,0,0,16'h5555,16'h2222});
    v('{0,0,0,1,1,16'h0104,16'h5678,0,0},       '{0,1,16'h0100,16'h1234,0,0,0,1,0,16'h5555,16'h2222});
    v('{0,0,0,1,1,16'h0104,16'h5678,1,16'h9999},'{1,1,16'h0104,16'h5678,0,1,0,0,0,16'h5555,16'h2222});
    v('{0,0,0,0,0,0,0,0,0},                     '{0,1,16'h0104,16'h5678,0,0,0,0,0,16'h5555,16'h2222});
    v('{0,1,16'h0030,0,0,0,0,0,0},              '{0,1,16'h0104,16'h5678,0,0,1,0,0,16'h5555,16'h2222});
    v('{0,1,16'h0030,0,0,0,0,1,16'h0ABC},       '{1,0,16'h0030,16'h5678,1,0,0,0,0,16'h5555,16'h2222});
    v('{0,0,0,0,0,0,0,0,0},                     '{0,0,16'h0030,16'h5678,0,0,0,0,0,16'h0ABC,16'h2222});
    // reset mid-access; late mem_valid ignored
    v('{0,0,0,1,0,16'h0300,0,0,0},              '{0,0,16'h0030,16'h5678,0,0,0,1,0,16'h0ABC,16'h2222});
    v('{0,0,0,1,0,16'h0300,0,0,0},              '{1,0,16'h0300,0,0,0,0,1,0,16'h0ABC,16'h2222});
    v('{1,0,0,0,0,0,0,0,0},                     '{0,0,16'h0300,0,0,0,0,0,0,16'h0ABC,16'h2222});
    v('{0,0,0,0,0,0,0,0,0},                     '{0,0,0,0,0,0,0,0,0,0,0});
    v('{0,0,0,0,0,0,0,1,16'h7777},              '{0,0,0,0,0,0,0,0,0,0,0});
    v('{0,0,0,0,0,0,0,0,0},                     '{0,0,0,0,0,0,0,0,0,0,0});

    drive('{1,0,0,0,0,0,0,0,0});
    repeat (2) @(posedge clk);

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].i);
      #1;
      chk($sformatf("tbl%0d", k), sample(), tbl[k].o);
    end

    // Timeout: fetch granted at c=0, busy c=1..32, IDLE with err at c=33,
    // re-issued at c=34, completed at c=35. Checked as {en, ifd, ifs, err, addr}.
    for (int c = 0; c <= 35; c++) begin
      logic [19:0] exp_t;
      @(negedge clk);
      drive('{0,1,16'h0040,0,0,0,0,(c == 35),16'h6060});
      #1;
      exp_t = {(c == 1 || c == 34), (c == 35), (c != 35), (c >= 33),
               (c == 0) ? 16'h0000 : 16'h0040};
      chk($sformatf("timeout_c%0d", c),
          {51'd0, mem_en, if_done, if_stall, err, mem_addr}, {51'd0, exp_t});
    end
    @(negedge clk);
    drive('{0,0,0,0,0,0,0,0,0});
    #1;
    chk("timeout_sticky", {54'd0, err, if_rdata}, {54'd0, 1'b1, 16'h6060});
    @(negedge clk);
    drive('{1,0,0,0,0,0,0,0,0});
    @(negedge clk);
    drive('{0,0,0,0,0,0,0,0,0});
    #1;
    chk("err_cleared_by_rst", {70'd0, err}, 71'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
